// File: rtl/wimax_deinterleaver.sv
// wimax_deinterleaver: QPSK block deinterleaver (s=1) with ping-pong banks for bubble-free streaming
module wimax_deinterleaver #(
   parameter int NCBPS = 192,
   parameter int D = 16
) (
   input  logic clk_ref,
   input  logic rst_n,
   input  logic valid_in,
   input  logic data_in,
   output logic ready_out,
   output logic valid_out,
   output logic data_out,
   input  logic ready_in,
   output logic block_done
);
   localparam int R = NCBPS / D;
   localparam int CW = $clog2(R);
   localparam int RW = $clog2(D);
   localparam int AW = $clog2(NCBPS);
   localparam logic [CW-1:0] COL_LAST = CW'(R - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(D - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(NCBPS - 1);

   logic [1:0][NCBPS-1:0] bank;
   logic [1:0] full;
   logic wr_sel, rd_sel;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [AW-1:0] wr_addr, rd_addr;
   logic wr_acc, wr_last, rd_xfer, rd_last;

   always_comb begin
      ready_out = rst_n & ~full[wr_sel];
      valid_out = full[rd_sel];
      data_out = valid_out ? bank[rd_sel][rd_addr] : 1'b0;
      wr_addr = AW'(col) * AW'(D) + AW'(row);
      wr_acc = valid_in & ready_out;
      wr_last = wr_acc && col == COL_LAST && row == ROW_LAST;
      rd_xfer = valid_out & ready_in;
      rd_last = rd_xfer && rd_addr == ADDR_LAST;
   end

   // full set and clear always address different banks, so both may fire on one edge
   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         bank <= '0;
         full <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         col <= '0;
         row <= '0;
         rd_addr <= '0;
         block_done <= 1'b0;
      end else begin
         block_done <= rd_last;
         if (wr_acc) begin
            bank[wr_sel][wr_addr] <= data_in;
            col <= (col == COL_LAST) ? '0 : col + 1'b1;
            if (col == COL_LAST) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end
         if (wr_last) begin
            full[wr_sel] <= 1'b1;
            wr_sel <= ~wr_sel;
         end
         if (rd_xfer) rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
         if (rd_last) begin
            full[rd_sel] <= 1'b0;
            rd_sel <= ~rd_sel;
         end
      end
   end
endmodule

// File: tb/tb_wimax_deinterleaver.sv
// tb_wimax_deinterleaver: randomized and directed bench against an index-map reference model
module tb_wimax_deinterleaver;
   localparam logic [191:0] GOLD_IN = 192'h4b047dfa42f2a5d5f61c021a5851e9a309a24fd58086bd1e;
   localparam logic [191:0] GOLD_OUT = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

   logic clk_ref = 1'b0, rst_n = 1'b0, valid_in = 1'b0, data_in = 1'b0, ready_in = 1'b0;
   logic ready_out, valid_out, data_out, block_done;
   int nvec = 0, nerr = 0, cyc = 0, acc = 0, back = -1;
   bit strm = 0, bp = 0, drop = 0, rnd_rdy = 0;
   logic outq[$];
   int outcyc[$], doneq[$];

   wimax_deinterleaver #(.NCBPS(192), .D(16)) dut (
      .clk_ref(clk_ref), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
      .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
      .ready_in(ready_in), .block_done(block_done)
   );

   always #5 clk_ref = ~clk_ref;
   always @(posedge clk_ref) cyc <= cyc + 1;

   always @(negedge clk_ref) begin
      if (valid_out && ready_in) begin
         outq.push_back(data_out);
         outcyc.push_back(cyc);
      end
      if (block_done) doneq.push_back(cyc);
      if (valid_in && ready_out) acc++;
      if (strm && !ready_out) drop = 1;
      if (bp && ready_out && back < 0) back = cyc;
   end

   always @(posedge clk_ref) if (rnd_rdy) begin
      #1;
      ready_in = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   // received bit j lands at original index k = 16*(j mod 12) + j/12
   function automatic logic [191:0] deint(input logic [191:0] blk);
      logic [191:0] o = '0;
      for (int j = 0; j < 192; j++) o[191 - (16 * (j % 12) + j / 12)] = blk[191 - j];
      return o;
   endfunction

   function automatic logic [191:0] blk_at(input int base);
      logic [191:0] o = '0;
      for (int k = 0; k < 192; k++) if (base + k < outq.size()) o[191 - k] = outq[base + k];
      return o;
   endfunction

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_ref);
      #1;
   endtask

   task automatic send_bit(input logic b, input int gap);
      int t = 0;
      valid_in = 1'b0;
      repeat (gap) begin
         @(posedge clk_ref);
         #1;
      end
      valid_in = 1'b1;
      data_in = b;
      @(negedge clk_ref);
      while (!ready_out && t < 3000) begin
         @(negedge clk_ref);
         t++;
      end
      if (!ready_out) check("accept_timeout", 0, 1);
      @(posedge clk_ref);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic send_block(input logic [191:0] blk, input int maxgap);
      for (int j = 0; j < 192; j++)
         send_bit(blk[191 - j], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic wait_out(input int n);
      int t = 0;
      while (outq.size() < n && t < 5000) begin
         @(posedge clk_ref);
         t++;
      end
      #1;
      if (outq.size() < n) check("output_timeout", outq.size(), n);
   endtask

   initial begin
      logic [191:0] b, e;
      logic [191:0] rb[4];
      int js[2] = '{13, 191};
      int ks[2] = '{17, 191};
      repeat (5) @(negedge clk_ref);
      check("rst_ready_out", ready_out, 0);
      check("rst_valid_out", valid_out, 0);
      check("rst_data_out", data_out, 0);
      @(posedge clk_ref);
      #1 rst_n = 1'b1;
      @(negedge clk_ref);
      check("post_rst_ready_out", ready_out, 1);
      check("post_rst_valid_out", valid_out, 0);
      check("post_rst_block_done", block_done, 0);
      idle(1);
      ready_in = 1'b1;

      outq.delete(); outcyc.delete(); doneq.delete();
      send_block(GOLD_IN, 0);
      check("golden_no_early_out", outq.size(), 0);
      check("golden_valid_rise", valid_out, 1);
      wait_out(192);
      idle(3);
      check("golden_block", blk_at(0), GOLD_OUT);
      check("golden_model", blk_at(0), deint(GOLD_IN));
      check("golden_out_count", outq.size(), 192);
      check("golden_done_count", doneq.size(), 1);
      if (doneq.size() > 0) check("golden_done_time", doneq[0], outcyc[191] + 1);
      check("golden_idle_valid", valid_out, 0);

      for (int i = 0; i < 2; i++) begin
         b = '0; b[191 - js[i]] = 1'b1;
         e = '0; e[191 - ks[i]] = 1'b1;
         outq.delete();
         send_block(b, 0);
         wait_out(192);
         check($sformatf("index_map_j%0d", js[i]), blk_at(0), e);
         check($sformatf("index_model_j%0d", js[i]), blk_at(0), deint(b));
         idle(3);
      end

      outq.delete(); outcyc.delete(); doneq.delete();
      drop = 0; strm = 1;
      repeat (3) send_block(GOLD_IN, 0);
      wait_out(576);
      strm = 0;
      idle(3);
      for (int i = 0; i < 3; i++) check($sformatf("stream_block%0d", i), blk_at(192 * i), GOLD_OUT);
      check("stream_ready_drop", drop, 0);
      if (outcyc.size() >= 576) check("stream_contiguous", outcyc[575] - outcyc[0], 575);
      check("stream_done_count", doneq.size(), 3);
      if (doneq.size() == 3) begin
         check("stream_done_gap1", doneq[1] - doneq[0], 192);
         check("stream_done_gap2", doneq[2] - doneq[1], 192);
      end

      ready_in = 1'b0;
      outq.delete(); outcyc.delete();
      acc = 0;
      send_block(GOLD_IN, 0);
      send_block(GOLD_IN, 0);
      valid_in = 1'b1;
      data_in = 1'b1;
      idle(5);
      @(negedge clk_ref);
      check("bp_accepts", acc, 384);
      check("bp_ready_low", ready_out, 0);
      check("bp_valid_high", valid_out, 1);
      check("bp_data_k0", data_out, 0);
      idle(5);
      check("bp_data_hold", data_out, 0);
      check("bp_no_output", outq.size(), 0);
      valid_in = 1'b0;
      back = -1; bp = 1;
      ready_in = 1'b1;
      wait_out(384);
      bp = 0;
      idle(3);
      check("bp_block0", blk_at(0), GOLD_OUT);
      check("bp_block1", blk_at(192), GOLD_OUT);
      if (outcyc.size() >= 192) check("bp_ready_return", back, outcyc[191] + 1);

      outq.delete();
      for (int i = 0; i < 4; i++) for (int w = 0; w < 6; w++) rb[i][32 * w +: 32] = $urandom;
      rnd_rdy = 1;
      for (int i = 0; i < 4; i++) send_block(rb[i], 2);
      wait_out(768);
      rnd_rdy = 0;
      idle(2);
      ready_in = 1'b1;
      for (int i = 0; i < 4; i++) check($sformatf("rand_block%0d", i), blk_at(192 * i), deint(rb[i]));

      idle(3);
      outq.delete(); doneq.delete();
      for (int j = 0; j < 100; j++) send_bit(1'($urandom_range(0, 1)), 0);
      rst_n = 1'b0;
      @(negedge clk_ref);
      check("midrst_ready_low", ready_out, 0);
      check("midrst_valid_low", valid_out, 0);
      idle(1);
      rst_n = 1'b1;
      idle(250);
      check("midrst_valid_after", valid_out, 0);
      check("midrst_no_output", outq.size(), 0);
      send_block(GOLD_IN, 0);
      wait_out(192);
      idle(5);
      check("midrst_golden", blk_at(0), GOLD_OUT);
      check("midrst_out_count", outq.size(), 192);
      check("midrst_done_count", doneq.size(), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
